// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit, common-decoder 7-segment
//   display. A prescaler paces the digit scan, a frame counter paces blinking,
//   and a one-deep image buffer accepts new display images from a producer.
//   Buffered images are committed only at frame boundaries, so no frame ever
//   shows a mix of two images.
//
// Parameters
//   DIV           clk cycles each digit stays selected (>= 2)
//   BLINK_FRAMES  full 8-digit frames per blink half-period (>= 1)
//
// Ports
//   clk         in   1   clock, rising edge
//   rst         in   1   synchronous active-high reset
//   load_valid  in   1   producer offers a new image
//   load_ready  out  1   block can accept an image this cycle
//   load_data   in  32   eight hex digits, digit i = load_data[4i+3:4i]
//   load_en     in   8   per-digit enable (0 = blanked)
//   load_blink  in   8   per-digit blink enable
//   seg_code    out  5   0-15 = hex digit, 31 = blank
//   seg_sel     out  8   active-low one-hot digit select
//   frame_done  out  1   one-cycle pulse as digit 7's slot ends
module seg_scan_ctrl #(
    parameter int unsigned DIV          = 4,
    parameter int unsigned BLINK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_en,
    input  logic [7:0]  load_blink,
    output logic [4:0]  seg_code,
    output logic [7:0]  seg_sel,
    output logic        frame_done
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [4:0]    BLANK  = 5'd31;

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Scan timing state
    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_idx;
    logic [FW-1:0] r_fcnt;
    logic          r_blink_phase;

    // Image buffer state
    state_t        r_state;
    logic [31:0]   r_pend_data;
    logic [7:0]    r_pend_en;
    logic [7:0]    r_pend_blink;
    logic [31:0]   r_act_data;
    logic [7:0]    r_act_en;
    logic [7:0]    r_act_blink;

    logic          w_tick;
    logic          w_frame;
    logic [3:0]    w_nibble;

    assign w_tick  = (r_pcnt == P_LAST);
    assign w_frame = w_tick && (r_idx == 3'd7);

    // Prescaler, digit index, frame counter and blink phase run freely;
    // nothing on the load side can stall them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt        <= '0;
            r_idx         <= '0;
            r_fcnt        <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pcnt <= '0;
                r_idx  <= r_idx + 3'd1;
            end else begin
                r_pcnt <= r_pcnt + PW'(1);
            end

            if (w_frame) begin
                if (r_fcnt == F_LAST) begin
                    r_fcnt        <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end
        end
    end

    // One-deep image buffer. A capture made on a frame-boundary cycle lands
    // in the pending registers only, so it waits for the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_pend_data  <= '0;
            r_pend_en    <= '0;
            r_pend_blink <= '0;
            r_act_data   <= '0;
            r_act_en     <= '0;
            r_act_blink  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (load_valid) begin
                        r_pend_data  <= load_data;
                        r_pend_en    <= load_en;
                        r_pend_blink <= load_blink;
                        r_state      <= PENDING;
                    end
                end
                PENDING: begin
                    if (w_frame) begin
                        r_act_data  <= r_pend_data;
                        r_act_en    <= r_pend_en;
                        r_act_blink <= r_pend_blink;
                        r_state     <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign load_ready = (r_state == EMPTY);
    assign seg_sel    = ~(8'b0000_0001 << r_idx);
    assign frame_done = w_frame;
    assign w_nibble   = r_act_data[{r_idx, 2'b00} +: 4];

    always_comb begin
        seg_code = BLANK;
        if (r_act_en[r_idx] && !(r_act_blink[r_idx] && r_blink_phase)) begin
            seg_code = {1'b0, w_nibble};
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed scenarios with literal expectations,
// plus a cycle-count based model compared against the DUT on every cycle.
module tb_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLINK = 2;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic [7:0]  load_en = '0;
    logic [7:0]  load_blink = '0;
    logic [4:0]  seg_code;
    logic [7:0]  seg_sel;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_ctrl #(.DIV(DIV), .BLINK_FRAMES(BLINK)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_en    (load_en),
        .load_blink (load_blink),
        .seg_code   (seg_code),
        .seg_sel    (seg_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: everything derives from the number of cycles since reset plus
    // the image currently shown and the one waiting.
    // ------------------------------------------------------------------
    bit          m_on = 1'b0;
    int          m_cyc = 0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pdata, m_adata;
    logic [7:0]  m_pen, m_ablink, m_aen, m_pblink;

    function automatic bit m_boundary(input int c);
        return (c % FRAME) == FRAME - 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on    = 1'b1;
            m_cyc   = 0;
            m_pend  = 1'b0;
            m_adata = '0;
            m_aen   = '0;
            m_ablink = '0;
        end else if (m_on) begin
            if (m_pend && m_boundary(m_cyc)) begin
                m_adata  = m_pdata;
                m_aen    = m_pen;
                m_ablink = m_pblink;
                m_pend   = 1'b0;
            end else if (!m_pend && load_valid) begin
                m_pdata  = load_data;
                m_pen    = load_en;
                m_pblink = load_blink;
                m_pend   = 1'b1;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            int idx, bp, code;
            idx  = (m_cyc / DIV) % 8;
            bp   = ((m_cyc / FRAME) / BLINK) % 2;
            if (!m_aen[idx] || (m_ablink[idx] && bp == 1))
                code = 31;
            else
                code = (m_adata >> (4 * idx)) & 15;
            check("model_sel",   seg_sel,    255 - (1 << idx));
            check("model_code",  seg_code,   code);
            check("model_frame", frame_done, int'(m_boundary(m_cyc)));
            check("model_ready", load_ready, int'(!m_pend));
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios. After do_reset the bench sits at cycle 0; each
    // step() advances one cycle.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic offer(input logic [31:0] d, input logic [7:0] e, input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = d;
        load_en    = e;
        load_blink = b;
    endtask

    initial begin
        // Reset values and idle scan
        do_reset();
        check("rst_sel",   seg_sel,    8'hFE);
        check("rst_code",  seg_code,   31);
        check("rst_frame", frame_done, 0);
        check("rst_ready", load_ready, 1);
        step(4);  check("idle_sel4",  seg_sel, 8'hFD);
        step(4);  check("idle_sel8",  seg_sel, 8'hFB);
        step(22); check("idle_fd30",  frame_done, 0);
        step(1);  check("idle_fd31",  frame_done, 1);
                  check("idle_sel31", seg_sel, 8'h7F);
        step(1);  check("idle_fd32",  frame_done, 0);
                  check("idle_sel32", seg_sel, 8'hFE);
        step(31); check("idle_fd63",  frame_done, 1);
                  check("idle_code",  seg_code, 31);

        // Load while idx = 2
        do_reset();
        step(8);
        offer(32'h7654_3210, 8'hFF, 8'h00);
        step(1);  load_valid = 1'b0;
                  check("l30_ready9",  load_ready, 0);
        step(22); check("l30_code31",  seg_code, 31);
                  check("l30_fd31",    frame_done, 1);
        step(1);  check("l30_code32",  seg_code, 0);
                  check("l30_sel32",   seg_sel, 8'hFE);
                  check("l30_ready32", load_ready, 1);
        step(4);  check("l30_code36",  seg_code, 1);
        step(24); check("l30_code60",  seg_code, 7);
                  check("l30_sel60",   seg_sel, 8'h7F);

        // Second image held during PENDING
        do_reset();
        offer(32'hAAAA_AAAA, 8'hFF, 8'h00);
        step(1);
        offer(32'hBBBB_BBBB, 8'hFF, 8'h00);
                  check("l31_ready1",  load_ready, 0);
        step(31); check("l31_code32",  seg_code, 10);
                  check("l31_ready32", load_ready, 1);
        step(1);  check("l31_ready33", load_ready, 0);
        load_valid = 1'b0;
        step(30); check("l31_code63",  seg_code, 10);
        step(1);  check("l31_code64",  seg_code, 11);

        // Enable mask and blink
        do_reset();
        offer(32'h0000_000A, 8'h0F, 8'h01);
        step(1);  load_valid = 1'b0;
        step(31); check("l32_d0_f1",   seg_code, 10);
        step(4);  check("l32_d1_f1",   seg_code, 0);
        step(12); check("l32_d4_f1",   seg_code, 31);
        step(16); check("l32_d0_f2",   seg_code, 31);
        step(32); check("l32_d0_f3",   seg_code, 31);
        step(4);  check("l32_d1_f3",   seg_code, 0);
        step(28); check("l32_d0_f4",   seg_code, 10);

        // Capture on the frame-boundary cycle
        do_reset();
        step(31);
        offer(32'h1234_5678, 8'hFF, 8'h00);
        step(1);  load_valid = 1'b0;
                  check("l33_code32",  seg_code, 31);
                  check("l33_ready32", load_ready, 0);
        step(31); check("l33_code63",  seg_code, 31);
        step(1);  check("l33_code64",  seg_code, 8);
                  check("l33_ready64", load_ready, 1);

        // Reset while PENDING, coinciding with a frame boundary
        do_reset();
        offer(32'h9999_9999, 8'hFF, 8'h00);
        step(1);  load_valid = 1'b0;
        step(30);
        rst = 1'b1;
        step(1);  rst = 1'b0;
                  check("l34_sel",    seg_sel, 8'hFE);
                  check("l34_code",   seg_code, 31);
                  check("l34_frame",  frame_done, 0);
                  check("l34_ready",  load_ready, 1);
        step(32); check("l34_code32", seg_code, 31);
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
